fetch_sequencer: RTL and testbench

Parametrised next-generation control-flow unit for the 9-bit-ISA core. It replaces the fixed PC, registered-flag and done logic of the current core top with one block.
- Program counter with stall support.
- Absolute jump and conditional branches on the registered condition flag.
- Call/return through a hardware return stack.
- Sticky shift-carry register.
- Halt/fault state machine that drives done.
It sits between the control decoder / PC lookup table and the instruction ROM.

---
 rtl/seq_pkg.sv | 21 ++
 rtl/fetch_sequencer_ret_stack.sv | 50 +++++
 rtl/fetch_sequencer.sv | 103 ++++++++++
 tb/tb_fetch_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types for the fetch sequencer: control-flow opcodes and FSM states.
package seq_pkg;
    localparam int BR_OP_W = 3;

    typedef enum logic [BR_OP_W-1:0] {
        BR_NONE = 3'b000,
        BR_JMP  = 3'b001,
        BR_BRC  = 3'b010,
        BR_BRNC = 3'b011,
        BR_CALL = 3'b100,
        BR_RET  = 3'b101,
        BR_HALT = 3'b110,
        BR_RSVD = 3'b111
    } br_op_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } seq_state_t;
endpackage

// File: rtl/fetch_sequencer_ret_stack.sv
// Hardware return-address stack; push is ignored when full, pop when empty.
module ret_stack #(
    parameter int D  = 12,
    parameter int SD = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [D-1:0] din,
    output logic [D-1:0] top,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(SD + 1);

    logic [PW-1:0]        ptr_q, ptr_d;
    logic [SD-1:0][D-1:0] mem_q, mem_d;

    assign full  = (ptr_q == PW'(SD));
    assign empty = (ptr_q == '0);

    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        top   = '0;
        // ptr points one past the top entry
        for (int i = 0; i < SD; i++) begin
            if (!empty && PW'(i) == ptr_q - PW'(1)) top = mem_q[i];
        end
        if (push && !full) begin
            for (int i = 0; i < SD; i++) begin
                if (PW'(i) == ptr_q) mem_d[i] = din;
            end
            ptr_d = ptr_q + PW'(1);
        end else if (pop && !empty) begin
            ptr_d = ptr_q - PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
            mem_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            mem_q <= mem_d;
        end
    end
endmodule

// File: rtl/fetch_sequencer.sv
// Control-flow unit: PC, branch/call/return, condition and shift-carry flags,
// and the RUN/HALTED/FAULT state machine that drives done.
module fetch_sequencer
    import seq_pkg::*;
#(
    parameter int D         = 12,
    parameter int SD        = 4,
    parameter int DONE_ADDR = 128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic [BR_OP_W-1:0] br_op,
    input  logic [D-1:0]       target,
    input  logic               cnd_i,
    input  logic               sc_i,
    input  logic               update_sc,
    input  logic               invert_sc,
    output logic [D-1:0]       prog_ctr,
    output logic               cnd_q,
    output logic               sc_q,
    output logic               done,
    output logic               fault
);
    seq_state_t   state_q, state_d;
    logic [D-1:0] pc_q, pc_d, pc_inc;
    logic         cnd_d, sc_d;
    logic         push, pop, run;
    logic [D-1:0] stk_top;
    logic         stk_full, stk_empty;
    br_op_t       op;

    assign op     = br_op_t'(br_op);
    assign pc_inc = pc_q + D'(1);
    assign run    = (state_q == ST_RUN) && !stall;

    ret_stack #(.D(D), .SD(SD)) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_comb begin
        pc_d    = pc_q;
        cnd_d   = cnd_q;
        sc_d    = sc_q;
        state_d = state_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (run) begin
            cnd_d = cnd_i;
            if (invert_sc)      sc_d = ~sc_q;
            else if (update_sc) sc_d = sc_i;
            case (op)
                BR_JMP:  pc_d = target;
                BR_BRC:  pc_d = cnd_q ? target : pc_inc;
                BR_BRNC: pc_d = cnd_q ? pc_inc : target;
                BR_CALL: begin
                    if (stk_full) begin
                        state_d = ST_FAULT;
                    end else begin
                        push = 1'b1;
                        pc_d = target;
                    end
                end
                BR_RET: begin
                    if (stk_empty) begin
                        state_d = ST_FAULT;
                    end else begin
                        pop  = 1'b1;
                        pc_d = stk_top;
                    end
                end
                BR_HALT: state_d = ST_HALTED;
                default: pc_d = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            cnd_q   <= 1'b0;
            sc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnd_q   <= cnd_d;
            sc_q    <= sc_d;
        end
    end

    assign prog_ctr = pc_q;
    assign fault    = (state_q == ST_FAULT);
    // FAULT also reports done so a faulting program still terminates
    assign done     = (state_q != ST_RUN) || (pc_q == D'(DONE_ADDR));
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, corner
// sequences, and random stimulus against a queue-based reference model.
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  br_op;
    logic [11:0] target;
    logic        cnd_i, sc_i, update_sc, invert_sc;
    logic [11:0] prog_ctr;
    logic        cnd_q, sc_q, done, fault;

    fetch_sequencer #(.D(12), .SD(4), .DONE_ADDR(128)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .br_op     (br_op),
        .target    (target),
        .cnd_i     (cnd_i),
        .sc_i      (sc_i),
        .update_sc (update_sc),
        .invert_sc (invert_sc),
        .prog_ctr  (prog_ctr),
        .cnd_q     (cnd_q),
        .sc_q      (sc_q),
        .done      (done),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // reference model: 0 running, 1 halted, 2 faulted
    int m_pc, m_state;
    bit m_cnd, m_sc;
    int m_stk[$];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void m_reset();
        m_pc = 0; m_state = 0; m_cnd = 0; m_sc = 0;
        m_stk.delete();
    endfunction

    function automatic void m_step(int op, int tgt, bit c, bit s, bit upd, bit inv, bit stl);
        int nxt;
        if (m_state != 0 || stl) return;
        nxt = (m_pc + 1) % 4096;
        case (op)
            1: m_pc = tgt;
            2: m_pc = m_cnd ? tgt : nxt;
            3: m_pc = m_cnd ? nxt : tgt;
            4: if (m_stk.size() == 4) m_state = 2;
               else begin m_stk.push_back(nxt); m_pc = tgt; end
            5: if (m_stk.size() == 0) m_state = 2;
               else m_pc = m_stk.pop_back();
            6: m_state = 1;
            default: m_pc = nxt;
        endcase
        m_cnd = c;
        if (inv) m_sc = ~m_sc;
        else if (upd) m_sc = s;
    endfunction

    task automatic step(input int op, input int tgt, input bit c, input bit s,
                        input bit upd, input bit inv, input bit stl);
        br_op = 3'(op); target = 12'(tgt); cnd_i = c; sc_i = s;
        update_sc = upd; invert_sc = inv; stall = stl;
        @(posedge clk);
        m_step(op, tgt, c, s, upd, inv, stl);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 0; br_op = 0; target = 0;
        cnd_i = 0; sc_i = 0; update_sc = 0; invert_sc = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_reset();
    endtask

    task automatic check_model(input string tag);
        chk({tag, " pc"}, int'(prog_ctr), m_pc);
        chk({tag, " cnd"}, int'(cnd_q), int'(m_cnd));
        chk({tag, " sc"}, int'(sc_q), int'(m_sc));
        chk({tag, " done"}, int'(done), int'(m_state != 0 || m_pc == 128));
        chk({tag, " fault"}, int'(fault), int'(m_state == 2));
    endtask

    typedef struct {
        int op; int tgt; bit c; bit stl;
        int pc; bit dn; bit flt;
    } vec_t;
    vec_t tv[17];

    initial begin
        tv[0]  = '{0, 'h000, 1'b0, 1'b0, 'h001, 1'b0, 1'b0};
        tv[1]  = '{0, 'h000, 1'b1, 1'b0, 'h002, 1'b0, 1'b0};
        tv[2]  = '{2, 'h040, 1'b0, 1'b0, 'h040, 1'b0, 1'b0}; // BRC taken
        tv[3]  = '{2, 'h080, 1'b0, 1'b0, 'h041, 1'b0, 1'b0}; // BRC not taken
        tv[4]  = '{3, 'h010, 1'b1, 1'b0, 'h010, 1'b0, 1'b0}; // BRNC taken
        tv[5]  = '{3, 'h200, 1'b0, 1'b0, 'h011, 1'b0, 1'b0}; // BRNC not taken
        tv[6]  = '{1, 'h010, 1'b0, 1'b0, 'h010, 1'b0, 1'b0};
        tv[7]  = '{4, 'h100, 1'b0, 1'b0, 'h100, 1'b0, 1'b0};
        tv[8]  = '{0, 'h000, 1'b0, 1'b0, 'h101, 1'b0, 1'b0};
        tv[9]  = '{5, 'h000, 1'b0, 1'b0, 'h011, 1'b0, 1'b0};
        tv[10] = '{1, 'h300, 1'b0, 1'b1, 'h011, 1'b0, 1'b0}; // stalled
        tv[11] = '{1, 'hFFF, 1'b0, 1'b0, 'hFFF, 1'b0, 1'b0};
        tv[12] = '{0, 'h000, 1'b0, 1'b0, 'h000, 1'b0, 1'b0}; // wrap
        tv[13] = '{1, 128,   1'b0, 1'b0, 128,   1'b1, 1'b0};
        tv[14] = '{0, 'h000, 1'b0, 1'b0, 129,   1'b0, 1'b0};
        tv[15] = '{6, 'h000, 1'b0, 1'b0, 129,   1'b1, 1'b0};
        tv[16] = '{1, 'h005, 1'b0, 1'b0, 129,   1'b1, 1'b0}; // frozen

        // reset state
        do_reset();
        chk("reset pc", int'(prog_ctr), 0);
        chk("reset cnd", int'(cnd_q), 0);
        chk("reset sc", int'(sc_q), 0);
        chk("reset done", int'(done), 0);
        chk("reset fault", int'(fault), 0);

        for (int i = 0; i < 17; i++) begin
            step(tv[i].op, tv[i].tgt, tv[i].c, 1'b0, 1'b0, 1'b0, tv[i].stl);
            chk($sformatf("vec%0d pc", i), int'(prog_ctr), tv[i].pc);
            chk($sformatf("vec%0d done", i), int'(done), int'(tv[i].dn));
            chk($sformatf("vec%0d fault", i), int'(fault), int'(tv[i].flt));
        end

        // asynchronous reset mid-run
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            chk($sformatf("count pc%0d", i), int'(prog_ctr), i);
            if (i == 3) break;
        end
        #2 reset = 1'b1;
        #1 chk("async reset pc", int'(prog_ctr), 0);
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        step(0, 0, 0, 0, 0, 0, 0);
        chk("post reset pc", int'(prog_ctr), 1);

        // overflow on fifth nested call
        do_reset();
        for (int i = 1; i <= 4; i++) step(4, i * 'h100, 0, 0, 0, 0, 0);
        chk("call4 pc", int'(prog_ctr), 'h400);
        chk("call4 fault", int'(fault), 0);
        step(4, 'h500, 0, 0, 0, 0, 0);
        chk("ovf pc", int'(prog_ctr), 'h400);
        chk("ovf fault", int'(fault), 1);
        chk("ovf done", int'(done), 1);
        step(1, 'h000, 0, 0, 0, 0, 0);
        chk("ovf frozen pc", int'(prog_ctr), 'h400);

        // underflow on empty stack
        do_reset();
        step(5, 0, 0, 0, 0, 0, 0);
        chk("unf pc", int'(prog_ctr), 0);
        chk("unf fault", int'(fault), 1);
        chk("unf done", int'(done), 1);

        // shift-carry update / invert priority / stall
        do_reset();
        step(0, 0, 0, 1, 1, 0, 0);
        chk("sc load", int'(sc_q), 1);
        step(0, 0, 0, 1, 1, 1, 0);
        chk("sc inv over upd", int'(sc_q), 0);
        step(0, 0, 0, 1, 0, 1, 1);
        chk("sc stall", int'(sc_q), 0);
        chk("sc stall pc", int'(prog_ctr), 2);

        // random stimulus against the model
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            int op, tgt;
            if (m_state != 0 && $urandom_range(0, 3) == 0) do_reset();
            op  = $urandom_range(0, 7);
            tgt = ($urandom_range(0, 9) == 0) ? 128 : $urandom_range(0, 4095);
            step(op, tgt, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 4) == 0);
            check_model($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
